// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Register-programmed soft-start controller for a 4-channel PWM. Software sets
// enables, per-channel target duties and a step size through a small bus.
// While ramping, each enabled channel's duty moves toward its target by STEP
// once every TICK_DIV clock cycles.
//
// Ports
//   clk, rst_n          system clock (rising edge) and async active-low reset
//   bus_we, bus_re      single-cycle write / read strobes
//   bus_addr            word address: 0 CTRL, 1 TARGET, 2 STEP, 3 STATUS, 4 CURRENT
//   bus_wdata           write data
//   bus_rdata           registered read data, valid while bus_ready is high
//   bus_ready           one-cycle acknowledge, one cycle after any strobe
//   pwm_enable          channel enables (bit n = channel n+1)
//   duty_ch1..duty_ch4  current ramped duty per channel
//   ramp_busy           high while ramping
//   ramp_done           one-cycle pulse on the cycle a ramp completes
module pwm_ramp_ctrl #(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [3:0]  pwm_enable,
  output logic [7:0]  duty_ch1,
  output logic [7:0]  duty_ch2,
  output logic [7:0]  duty_ch3,
  output logic [7:0]  duty_ch4,
  output logic        ramp_busy,
  output logic        ramp_done
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tick;
  logic [3:0]       ctrl, ctrl_nxt;
  logic [3:0][7:0]  tgt;
  logic [3:0][7:0]  cur, cur_nxt;
  logic [7:0]       step;
  logic [31:0]      rd_val;
  logic             wr_ctrl, wr_tgt, wr_step;
  logic             start, settled, step_now;

  // One step of a channel toward its target. Sums and limits are formed at
  // 9 bits so a large STEP saturates at the target instead of wrapping.
  // STEP of zero means "jump straight to target".
  function automatic logic [7:0] step_toward(input logic [7:0] c,
                                             input logic [7:0] t,
                                             input logic [7:0] s);
    logic [8:0] up;
    logic [8:0] lim;
    logic [7:0] r;
    up  = {1'b0, c} + {1'b0, s};
    lim = {1'b0, t} + {1'b0, s};
    if ((s == 8'd0) || (c == t))
      r = t;
    else if (c < t)
      r = (up >= {1'b0, t}) ? t : up[7:0];
    else
      r = ({1'b0, c} > lim) ? (c - s) : t;
    return r;
  endfunction

  assign wr_ctrl  = bus_we && (bus_addr == 3'd0);
  assign wr_tgt   = bus_we && (bus_addr == 3'd1);
  assign wr_step  = bus_we && (bus_addr == 3'd2);
  assign ctrl_nxt = wr_ctrl ? bus_wdata[3:0] : ctrl;

  // Anything that may move a target away from the current duty starts a ramp:
  // a new target, a new step, or a channel turning on (it restarts from 0).
  assign start    = wr_tgt || wr_step || (wr_ctrl && (|(bus_wdata[3:0] & ~ctrl)));
  assign step_now = (state == RAMP) && (tick == TICK_LAST);

  always_comb begin
    settled = 1'b1;
    for (int n = 0; n < 4; n++)
      if (ctrl[n] && (cur[n] != tgt[n])) settled = 1'b0;
  end

  // A channel being disabled (including by this cycle's CTRL write) is zeroed
  // immediately so re-enabling soft-starts it from 0.
  always_comb begin
    cur_nxt = cur;
    for (int n = 0; n < 4; n++) begin
      if (!ctrl_nxt[n])
        cur_nxt[n] = 8'd0;
      else if (step_now && ctrl[n])
        cur_nxt[n] = step_toward(cur[n], tgt[n], step);
    end
  end

  // A start request arriving on the settled cycle keeps the ramp running so
  // the new setting is not lost.
  always_comb begin
    state_nxt = state;
    ramp_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RAMP;
      RAMP: if (settled && !start) begin
        state_nxt = IDLE;
        ramp_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = 32'd0;
    case (bus_addr)
      3'd0:    rd_val = {28'd0, ctrl};
      3'd1:    rd_val = tgt;
      3'd2:    rd_val = {24'd0, step};
      3'd3:    rd_val = {31'd0, ramp_busy};
      3'd4:    rd_val = cur;
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Tick counter runs only while staying in RAMP, so every ramp entry starts
  // from 0 and register writes mid-ramp never restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick <= '0;
    else if ((state == RAMP) && (state_nxt == RAMP))
      tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
    else
      tick <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      tgt  <= '0;
      step <= '0;
      cur  <= '0;
    end else begin
      ctrl <= ctrl_nxt;
      cur  <= cur_nxt;
      if (wr_tgt)  tgt  <= bus_wdata;
      if (wr_step) step <= bus_wdata[7:0];
    end
  end

  // A combined write+read performs only the write and returns zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_we || bus_re;
      bus_rdata <= (bus_re && !bus_we) ? rd_val : 32'd0;
    end
  end

  assign pwm_enable = ctrl;
  assign ramp_busy  = (state == RAMP);
  assign duty_ch1   = cur[0];
  assign duty_ch2   = cur[1];
  assign duty_ch3   = cur[2];
  assign duty_ch4   = cur[3];

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
// Self-checking bench for pwm_ramp_ctrl with TICK_DIV=4. Directed scenarios
// with hand-computed expectations, followed by randomized bus traffic, while a
// behavioural model tracks the expected outputs every cycle.
module tb_pwm_ramp_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [2:0]  bus_addr = 3'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [3:0]  pwm_enable;
  logic [7:0]  duty_ch1, duty_ch2, duty_ch3, duty_ch4;
  logic        ramp_busy;
  logic        ramp_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_ctrl;
  int m_step;
  int m_tgt[4];
  int m_cur[4];
  int m_rdata;
  int m_cycles;
  bit m_ramp;
  bit m_ready;

  pwm_ramp_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .pwm_enable (pwm_enable),
    .duty_ch1   (duty_ch1),
    .duty_ch2   (duty_ch2),
    .duty_ch3   (duty_ch3),
    .duty_ch4   (duty_ch4),
    .ramp_busy  (ramp_busy),
    .ramp_done  (ramp_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_enabled(input int n);
    return ((m_ctrl >> n) & 1) != 0;
  endfunction

  function automatic bit m_settled();
    for (int n = 0; n < 4; n++)
      if (m_enabled(n) && (m_cur[n] != m_tgt[n])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_start(input bit we, input logic [2:0] a, input logic [31:0] d);
    if (!we) return 1'b0;
    if ((a == 3'd1) || (a == 3'd2)) return 1'b1;
    if (a == 3'd0) return ((int'(d[3:0]) & ~m_ctrl & 15) != 0);
    return 1'b0;
  endfunction

  function automatic int m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_ctrl;
      3'd1: return (m_tgt[3] << 24) | (m_tgt[2] << 16) | (m_tgt[1] << 8) | m_tgt[0];
      3'd2: return m_step;
      3'd3: return m_ramp ? 1 : 0;
      3'd4: return (m_cur[3] << 24) | (m_cur[2] << 16) | (m_cur[1] << 8) | m_cur[0];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_step = 0; m_rdata = 0; m_cycles = 0;
    m_ramp = 1'b0; m_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      m_tgt[n] = 0;
      m_cur[n] = 0;
    end
  endtask

  // One clock of the specification's rules, using the inputs present at the edge.
  task automatic model_step();
    bit st, stl, stepping;
    int nctrl, rv;
    stl = m_settled();
    st = m_start(bus_we, bus_addr, bus_wdata);
    stepping = m_ramp && ((m_cycles % TD) == TD - 1);
    rv = m_read(bus_addr);
    nctrl = (bus_we && (bus_addr == 3'd0)) ? int'(bus_wdata[3:0]) : m_ctrl;
    for (int n = 0; n < 4; n++) begin
      if (((nctrl >> n) & 1) == 0)
        m_cur[n] = 0;
      else if (stepping && m_enabled(n)) begin
        if (m_step == 0)
          m_cur[n] = m_tgt[n];
        else if (m_cur[n] < m_tgt[n])
          m_cur[n] = (m_cur[n] + m_step < m_tgt[n]) ? m_cur[n] + m_step : m_tgt[n];
        else if (m_cur[n] > m_tgt[n])
          m_cur[n] = (m_cur[n] - m_step > m_tgt[n]) ? m_cur[n] - m_step : m_tgt[n];
      end
    end
    if (!m_ramp) begin
      if (st) begin
        m_ramp = 1'b1;
        m_cycles = 0;
      end
    end else if (stl && !st)
      m_ramp = 1'b0;
    else
      m_cycles++;
    m_ready = bus_we || bus_re;
    m_rdata = (bus_re && !bus_we) ? rv : 0;
    if (bus_we) begin
      case (bus_addr)
        3'd0: m_ctrl = nctrl;
        3'd1: for (int n = 0; n < 4; n++) m_tgt[n] = int'((bus_wdata >> (8 * n)) & 32'hFF);
        3'd2: m_step = int'(bus_wdata[7:0]);
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison, mid-cycle after inputs for the cycle have settled.
  initial begin
    forever begin
      @(posedge clk);
      #6;
      check_output("bus_ready", bus_ready, m_ready);
      check_output("bus_rdata", bus_rdata, m_rdata);
      check_output("pwm_enable", pwm_enable, m_ctrl);
      check_output("duty_ch1", duty_ch1, m_cur[0]);
      check_output("duty_ch2", duty_ch2, m_cur[1]);
      check_output("duty_ch3", duty_ch3, m_cur[2]);
      check_output("duty_ch4", duty_ch4, m_cur[3]);
      check_output("ramp_busy", ramp_busy, m_ramp);
      check_output("ramp_done", ramp_done,
                   m_ramp && m_settled() && !m_start(bus_we, bus_addr, bus_wdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Drives one transfer for a single cycle; returns just after the sampling
  // edge, when bus_ready and bus_rdata belong to this transfer.
  task automatic apply_stimulus(input bit we, input bit re, input logic [2:0] a, input logic [31:0] d);
    bus_we = we;
    bus_re = re;
    bus_addr = a;
    bus_wdata = d;
    tick();
    bus_we = 1'b0;
    bus_re = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    apply_stimulus(1'b1, 1'b0, a, d);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk);
    tick();
    check_output("reset duty_ch1", duty_ch1, 0);
    check_output("reset ramp_busy", ramp_busy, 0);
    check_output("reset bus_ready", bus_ready, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Basic ramp up 0 -> 64 in steps of 16
    bus_write(3'd2, 32'd16);
    wait_cycles(4);
    bus_write(3'd1, 32'd64);
    wait_cycles(4);
    bus_write(3'd0, 32'h1);
    check_output("up busy on entry", ramp_busy, 1);
    check_output("up pwm_enable", pwm_enable, 4'h1);
    for (int k = 1; k <= 4; k++) begin
      wait_cycles(3);
      check_output("up duty before step", duty_ch1, 16 * (k - 1));
      wait_cycles(1);
      check_output("up duty after step", duty_ch1, 16 * k);
    end
    check_output("up ramp_done", ramp_done, 1);
    wait_cycles(1);
    check_output("up busy falls", ramp_busy, 0);
    check_output("up done single", ramp_done, 0);

    // Ramp down 64 -> 10 with STEP 40, clamped at target
    bus_write(3'd2, 32'd40);
    wait_cycles(4);
    bus_write(3'd1, 32'd10);
    wait_cycles(4);
    check_output("down first step", duty_ch1, 24);
    wait_cycles(4);
    check_output("down clamp", duty_ch1, 10);
    check_output("down done", ramp_done, 1);
    wait_cycles(2);

    // Large step without 8-bit wrap, then STEP 0 jumps
    bus_write(3'd2, 32'd200);
    wait_cycles(4);
    bus_write(3'd1, 32'd100);
    wait_cycles(4);
    check_output("big step to 100", duty_ch1, 100);
    wait_cycles(2);
    bus_write(3'd1, 32'd250);
    wait_cycles(3);
    check_output("big step hold", duty_ch1, 100);
    wait_cycles(1);
    check_output("big step no wrap", duty_ch1, 250);
    wait_cycles(2);
    bus_write(3'd2, 32'd0);
    wait_cycles(4);
    bus_write(3'd1, 32'd7);
    wait_cycles(3);
    check_output("step0 hold", duty_ch1, 250);
    wait_cycles(1);
    check_output("step0 jump", duty_ch1, 7);
    wait_cycles(2);

    // Disable mid-ramp, then re-enable soft-starts from 0
    bus_write(3'd2, 32'd16);
    wait_cycles(4);
    bus_write(3'd1, 32'd200);
    wait_cycles(4);
    check_output("mid ramp 23", duty_ch1, 23);
    wait_cycles(4);
    check_output("mid ramp 39", duty_ch1, 39);
    wait_cycles(1);
    bus_write(3'd0, 32'h0);
    check_output("disable duty zero", duty_ch1, 0);
    check_output("disable pwm_enable", pwm_enable, 0);
    check_output("disable done", ramp_done, 1);
    wait_cycles(1);
    check_output("disable busy falls", ramp_busy, 0);
    bus_write(3'd0, 32'h1);
    check_output("reenable busy", ramp_busy, 1);
    check_output("reenable from zero", duty_ch1, 0);
    wait_cycles(4);
    check_output("reenable first step", duty_ch1, 16);

    // Bus corner cases
    apply_stimulus(1'b1, 1'b1, 3'd1, 32'h1122_3344);
    check_output("we+re ready", bus_ready, 1);
    check_output("we+re rdata", bus_rdata, 0);
    tick();
    check_output("we+re single ready", bus_ready, 0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 32'd0);
    check_output("we+re write applied", bus_rdata, 32'h1122_3344);
    apply_stimulus(1'b0, 1'b1, 3'd6, 32'd0);
    check_output("addr6 rdata", bus_rdata, 0);
    check_output("addr6 ready", bus_ready, 1);
    apply_stimulus(1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 1'b1, 3'd6, 32'd0);
    check_output("addr6 write ignored", bus_rdata, 0);
    apply_stimulus(1'b0, 1'b1, 3'd2, 32'd0);
    check_output("read step", bus_rdata, 16);
    apply_stimulus(1'b0, 1'b1, 3'd3, 32'd0);
    check_output("read status busy", bus_rdata, 1);

    // Reset in the middle of a ramp
    bus_write(3'd1, 32'd255);
    wait_cycles(6);
    rst_n = 1'b0;
    #1;
    check_output("rst duty_ch1", duty_ch1, 0);
    check_output("rst busy", ramp_busy, 0);
    check_output("rst done", ramp_done, 0);
    check_output("rst pwm_enable", pwm_enable, 0);
    check_output("rst ready", bus_ready, 0);
    check_output("rst rdata", bus_rdata, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    apply_stimulus(1'b0, 1'b1, 3'd4, 32'd0);
    check_output("rst current", bus_rdata, 0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 32'd0);
    check_output("rst target", bus_rdata, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 9) < 6) begin
        bit we, re;
        logic [2:0] a;
        logic [31:0] d;
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
        if (!we && !re) re = 1'b1;
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a == 3'd2 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 80));
        apply_stimulus(we, re, a, d);
      end else begin
        wait_cycles($urandom_range(1, 12));
      end
    end
    wait_cycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
